// File: rtl/phy_tx_pkg.sv
// Shared symbol codes, link state and word geometry helper for the multilane TX PHY.
package phy_tx_pkg;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;
    localparam logic [7:0] SKP = 8'h1C;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } tx_state_t;

    function automatic int syms_per_word(input int data_w, input int sym_w);
        return data_w / sym_w;
    endfunction

endpackage

// File: rtl/phy_tx_lane.sv
// One serial lane: a pending word slot, the word being sent, and the symbol shift register.
module phy_tx_lane
    import phy_tx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SYM_W  = 8
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              boundary,
    input  logic              sync_mode,
    input  logic              skp_now,
    input  logic              load_pend,
    input  logic [DATA_W-1:0] pend_data,
    output logic              pend_free,
    output logic              tx_bit
);
    localparam int SPW = syms_per_word(DATA_W, SYM_W);
    localparam int RW  = $clog2(SPW + 1);

    logic [DATA_W-1:0] pend_word;
    logic [DATA_W-1:0] cur_word;
    logic              pend_vld;
    logic [RW-1:0]     cur_rem;
    logic [SYM_W-1:0]  shift_reg;
    logic [SYM_W-1:0]  next_sym;
    logic              lane_step;
    logic              take_pend;

    // A SKP boundary freezes the word in flight; it resumes at the next boundary.
    assign lane_step = boundary && !sync_mode && !skp_now;
    assign take_pend = lane_step && (cur_rem == '0) && pend_vld;
    assign pend_free = !pend_vld || take_pend;
    assign tx_bit    = shift_reg[SYM_W-1];

    always_comb begin
        next_sym = SYM_W'(IDL);
        if (sync_mode)
            next_sym = SYM_W'(COM);
        else if (skp_now)
            next_sym = SYM_W'(SKP);
        else if (cur_rem != '0)
            next_sym = cur_word[DATA_W-1 -: SYM_W];
        else if (pend_vld)
            next_sym = pend_word[DATA_W-1 -: SYM_W];
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            shift_reg <= '0;
            pend_vld  <= 1'b0;
            cur_rem   <= '0;
        end else begin
            shift_reg <= boundary ? next_sym : (shift_reg << 1);
            if (load_pend)
                pend_vld <= 1'b1;
            else if (take_pend)
                pend_vld <= 1'b0;
            if (take_pend)
                cur_rem <= RW'(SPW - 1);
            else if (lane_step && (cur_rem != '0))
                cur_rem <= cur_rem - 1'b1;
        end
    end

    // Word storage carries no reset; the valid/remaining counts above qualify it.
    always_ff @(posedge clk_32f) begin
        if (load_pend)
            pend_word <= pend_data;
        if (take_pend)
            cur_word <= pend_word << SYM_W;
        else if (lane_step && (cur_rem != '0))
            cur_word <= cur_word << SYM_W;
    end

endmodule

// File: rtl/phy_tx_multilane.sv
// Multilane serial TX PHY on the bit clock: input FIFO, round-robin word striping, COM/IDL framing.
// Define PHY_TX_SKP_EN to build in periodic SKP insertion across all lanes.
module phy_tx_multilane
    import phy_tx_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int SYM_W        = 8,
    parameter int LANES        = 2,
    parameter int DEPTH        = 4,
    parameter int SYNC_SYMS    = 4,
    parameter int SKP_INTERVAL = 64
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic [LANES-1:0]       phy_tx_out,
    output logic                   link_active,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int BW  = (SYM_W > 1) ? $clog2(SYM_W) : 1;
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SCW = $clog2(SYNC_SYMS + 1);

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [SCW-1:0]    sync_cnt;
    logic [LW-1:0]     rr_ptr;
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              boundary;
    logic              sync_mode;
    logic              skp_now;
    logic              push;
    logic              pop;
    logic [LANES-1:0]  pend_free;
    logic [LANES-1:0]  load_pend;

    assign boundary  = (bit_cnt == BW'(SYM_W - 1));
    assign sync_mode = (state == SYNC);
    assign ready_out = !reset && (fifo_count < CW'(DEPTH));
    assign push      = valid_in && ready_out;
    // Only words already stored can pop, so a push never bypasses to a lane in the same cycle.
    assign pop       = (state == ACTIVE) && (fifo_count != '0) && pend_free[rr_ptr];

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            bit_cnt    <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                rr_ptr <= (rr_ptr == LW'(LANES - 1)) ? '0 : rr_ptr + 1'b1;
            end
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (push)
            fifo_mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state    <= SYNC;
            sync_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (boundary && sync_mode)
                sync_cnt <= sync_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (sync_mode && boundary && (sync_cnt == SCW'(SYNC_SYMS - 1)))
            state_nxt = ACTIVE;
    end

    always_comb begin
        link_active = (state == ACTIVE);
    end

`ifdef PHY_TX_SKP_EN
    localparam int KW = $clog2(SKP_INTERVAL + 1);
    logic [KW-1:0] skp_cnt;

    assign skp_now = boundary && !sync_mode && (skp_cnt == KW'(SKP_INTERVAL - 1));

    always_ff @(posedge clk_32f) begin
        if (reset)
            skp_cnt <= '0;
        else if (boundary && !sync_mode)
            skp_cnt <= skp_now ? '0 : skp_cnt + 1'b1;
    end
`else
    // Without SKP support the interval is meaningless; this folds to constant low.
    assign skp_now = boundary && (SKP_INTERVAL < 1);
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign load_pend[i] = pop && (rr_ptr == LW'(i));

        phy_tx_lane #(
            .DATA_W (DATA_W),
            .SYM_W  (SYM_W)
        ) u_lane (
            .clk_32f   (clk_32f),
            .reset     (reset),
            .boundary  (boundary),
            .sync_mode (sync_mode),
            .skp_now   (skp_now),
            .load_pend (load_pend[i]),
            .pend_data (fifo_mem[rd_ptr]),
            .pend_free (pend_free[i]),
            .tx_bit    (phy_tx_out[i])
        );
    end

endmodule

// File: tb/tb_phy_tx_multilane.sv
// Randomised, model-checked bench for phy_tx_multilane (default parameters, 2 lanes).
module tb_phy_tx_multilane;
    localparam int DATA_W    = 32;
    localparam int SYM_W     = 8;
    localparam int LANES     = 2;
    localparam int DEPTH     = 4;
    localparam int SYNC_SYMS = 4;
    localparam int SPW       = DATA_W / SYM_W;
`ifdef PHY_TX_SKP_EN
    localparam int SKP_INTERVAL = 8;
`else
    localparam int SKP_INTERVAL = 64;
`endif

    logic              clk_32f = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] data_in = '0;
    logic              valid_in = 1'b0;
    logic              ready_out;
    logic [LANES-1:0]  phy_tx_out;
    logic              link_active;
    logic [2:0]        fifo_count;

    always #5 clk_32f = ~clk_32f;

    phy_tx_multilane #(
        .DATA_W(DATA_W), .SYM_W(SYM_W), .LANES(LANES), .DEPTH(DEPTH),
        .SYNC_SYMS(SYNC_SYMS), .SKP_INTERVAL(SKP_INTERVAL)
    ) dut (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .phy_tx_out(phy_tx_out), .link_active(link_active),
        .fifo_count(fifo_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words as queues of bytes, lanes as symbol streams.
    int          m_bitcnt = 0, m_synccnt = 0, m_skpcnt = 0, m_rr = 0;
    bit          m_active = 0, m_pushed = 0;
    logic [31:0] m_fifo[$];
    bit          m_pv[LANES];
    logic [31:0] m_pw[LANES];
    logic [7:0]  m_bytes[LANES][$];
    logic [7:0]  m_sr[LANES];

    task automatic model_step();
        bit bnd, skp;
        int fifo_n;
        logic [7:0] sym;
        if (reset) begin
            m_bitcnt = 0; m_synccnt = 0; m_skpcnt = 0; m_rr = 0;
            m_active = 0; m_pushed = 0;
            m_fifo.delete();
            for (int l = 0; l < LANES; l++) begin
                m_pv[l] = 0; m_bytes[l].delete(); m_sr[l] = 8'h00;
            end
        end else begin
            bnd = (m_bitcnt == SYM_W - 1);
            skp = 0;
`ifdef PHY_TX_SKP_EN
            skp = bnd && m_active && (m_skpcnt == SKP_INTERVAL - 1);
`endif
            fifo_n = m_fifo.size();
            m_pushed = valid_in && (fifo_n < DEPTH);
            for (int l = 0; l < LANES; l++) begin
                if (!bnd) begin
                    m_sr[l] = m_sr[l] << 1;
                end else begin
                    if (!m_active) sym = 8'hBC;
                    else if (skp) sym = 8'h1C;
                    else begin
                        if (m_bytes[l].size() == 0 && m_pv[l]) begin
                            for (int k = SPW - 1; k >= 0; k--) m_bytes[l].push_back(m_pw[l][k*8 +: 8]);
                            m_pv[l] = 0;
                        end
                        if (m_bytes[l].size() > 0) sym = m_bytes[l].pop_front();
                        else sym = 8'h7C;
                    end
                    m_sr[l] = sym;
                end
            end
            if (m_active && fifo_n > 0 && !m_pv[m_rr]) begin
                m_pw[m_rr] = m_fifo.pop_front();
                m_pv[m_rr] = 1;
                m_rr = (m_rr + 1) % LANES;
            end
            if (m_pushed) m_fifo.push_back(data_in);
            if (bnd) begin
                if (!m_active) begin
                    if (m_synccnt == SYNC_SYMS - 1) m_active = 1;
                    m_synccnt++;
                end else begin
                    m_skpcnt = skp ? 0 : m_skpcnt + 1;
                end
            end
            m_bitcnt = (m_bitcnt + 1) % SYM_W;
        end
    endtask

    initial forever begin
        @(posedge clk_32f);
        model_step();
    end

    // Per-cycle comparison plus a deserialiser that collects DUT symbols per lane.
    bit         chk_en = 0, saw_busy = 0;
    logic [7:0] cap[LANES][$];
    logic [7:0] csh[LANES];
    bit         cgo[LANES];

    initial forever begin
        @(posedge clk_32f);
        #1;
        if (chk_en) begin
            chk("phy_tx_out", phy_tx_out, {m_sr[1][7], m_sr[0][7]});
            chk("link_active", link_active, m_active);
            chk("fifo_count", fifo_count, m_fifo.size());
            chk("ready_out", ready_out, !reset && (m_fifo.size() < DEPTH));
            if (!reset && !ready_out) saw_busy = 1;
        end
        for (int l = 0; l < LANES; l++) begin
            if (reset) cgo[l] = 0;
            else begin
                if (m_bitcnt == 0) begin cgo[l] = 1; csh[l] = 8'h00; end
                if (cgo[l]) begin
                    csh[l] = {csh[l][6:0], phy_tx_out[l]};
                    if (m_bitcnt == SYM_W - 1) cap[l].push_back(csh[l]);
                end
            end
        end
    end

    function automatic logic [7:0] capb(input int l, input int i);
        if (i < 0 || i >= cap[l].size()) return 8'hEE;
        return cap[l][i];
    endfunction

    function automatic int find_byte(input int l, input logic [7:0] b);
        for (int i = 0; i < cap[l].size(); i++) if (cap[l][i] == b) return i;
        return -1;
    endfunction

    function automatic int first_data(input int l, input int from);
        for (int i = from; i < cap[l].size(); i++) if (cap[l][i] != 8'h7C) return i;
        return -1;
    endfunction

    task automatic clear_caps();
        for (int l = 0; l < LANES; l++) cap[l].delete();
    endtask

    task automatic align();
        int g = 0;
        do begin @(negedge clk_32f); g++; end while (m_bitcnt != 1 && g < 64);
    endtask

    task automatic send_word(input logic [31:0] w);
        int g = 0;
        bit done = 0;
        data_in = w; valid_in = 1;
        while (!done && g < 200) begin
            @(posedge clk_32f); #1;
            done = m_pushed; g++;
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL send_word: actual not accepted required accepted within 200 cycles");
        end
        @(negedge clk_32f); valid_in = 0;
    endtask

    task automatic send_stream(input int n, input logic [31:0] base);
        int idx = 0, g = 0;
        valid_in = 1; data_in = base;
        while (idx < n && g < 1000) begin
            @(posedge clk_32f); #1; g++;
            if (m_pushed) idx++;
            @(negedge clk_32f);
            data_in = base + idx; valid_in = (idx < n);
        end
        valid_in = 0;
        if (idx < n) begin
            n_checks++; n_errors++;
            $display("FAIL send_stream: actual %0d words required %0d", idx, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_32f); reset = 1; valid_in = 0;
        repeat (2) @(negedge clk_32f);
        reset = 0; clear_caps();
    endtask

    initial begin
        int s0, s1, mism, nz;
        logic [31:0] w;
        // Reset state
        repeat (3) @(posedge clk_32f);
        chk_en = 1;
        #1;
        chk("rst_phy_tx_out", phy_tx_out, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_link_active", link_active, 0);
        chk("rst_ready_out", ready_out, 0);

        // Start-up framing with no traffic
        @(negedge clk_32f); reset = 0; clear_caps();
        repeat (60) @(posedge clk_32f); #1;
        for (int i = 0; i < 4; i++) begin
            chk("sync_com_lane0", capb(0, i), 8'hBC);
            chk("sync_com_lane1", capb(1, i), 8'hBC);
        end
        chk("first_idl_lane0", capb(0, 4), 8'h7C);
        chk("first_idl_lane1", capb(1, 4), 8'h7C);
        chk("link_up", link_active, 1);

        // Two words striped over both lanes
        clear_caps();
        align();
        send_word(32'hAABBCCDD);
        send_word(32'h11223344);
        repeat (80) @(posedge clk_32f); #1;
        s0 = find_byte(0, 8'hAA);
        s1 = find_byte(1, 8'h11);
        chk("pair_found_lane0", s0 >= 0, 1);
        chk("pair_same_boundary", s0, s1);
        chk("pair_lane0_b1", capb(0, s0 + 1), 8'hBB);
        chk("pair_lane0_b3", capb(0, s0 + 3), 8'hDD);
        chk("pair_lane1_b2", capb(1, s1 + 2), 8'h33);
        chk("pair_lane1_b3", capb(1, s1 + 3), 8'h44);
        chk("pair_idle_after0", capb(0, s0 + 4), 8'h7C);
        chk("pair_idle_after1", capb(1, s1 + 4), 8'h7C);

        // Twelve back-to-back words: backpressure, ordering, no idle gaps
        clear_caps(); saw_busy = 0;
        align();
        send_stream(12, 32'h0);
        repeat (150) @(posedge clk_32f); #1;
        chk("stream_backpressure", saw_busy, 1);
        s0 = first_data(0, 0);
        s1 = first_data(1, 0);
        chk("stream_same_start", s0, s1);
        for (int l = 0; l < LANES; l++) begin
            mism = 0;
            for (int k = 0; k < 6; k++) begin
                w = 32'(2 * k + l);
                for (int b = 0; b < 4; b++)
                    if (capb(l, (l == 0 ? s0 : s1) + 4 * k + b) != w[31 - 8*b -: 8]) mism++;
            end
            chk(l == 0 ? "stream_lane0_bytes" : "stream_lane1_bytes", mism, 0);
            chk("stream_idle_after", capb(l, (l == 0 ? s0 : s1) + 24), 8'h7C);
        end

        // Words queued during start-up
        @(negedge clk_32f); reset = 1; valid_in = 0;
        @(negedge clk_32f); reset = 0; clear_caps();
        valid_in = 1; data_in = 32'hDEADBEEF;
        @(posedge clk_32f); #1; chk("sync_fill_1", fifo_count, 1);
        @(negedge clk_32f); data_in = 32'hCAFEF00D;
        @(posedge clk_32f); #1; chk("sync_fill_2", fifo_count, 2);
        @(negedge clk_32f); data_in = 32'h0BADF00D;
        @(posedge clk_32f); #1; chk("sync_fill_3", fifo_count, 3);
        chk("sync_still_down", link_active, 0);
        @(negedge clk_32f); valid_in = 0;
        repeat (100) @(posedge clk_32f); #1;
        chk("sync_word0_lane0", capb(0, 4), 8'hDE);
        chk("sync_word1_lane1", capb(1, 4), 8'hCA);
        chk("sync_word2_lane0", capb(0, 8), 8'h0B);
        chk("sync_idle_lane1", capb(1, 8), 8'h7C);

        // Reset in the middle of a word
        align();
        send_word(32'h55667788);
        send_word(32'h55667788);
        send_word(32'h55667788);
        repeat (12) @(posedge clk_32f);
        @(negedge clk_32f); reset = 1;
        @(posedge clk_32f); #1;
        chk("midrst_phy_tx_out", phy_tx_out, 0);
        chk("midrst_fifo_count", fifo_count, 0);
        chk("midrst_link_active", link_active, 0);
        @(negedge clk_32f); reset = 0; clear_caps();
        repeat (100) @(posedge clk_32f); #1;
        chk("midrst_com_lane0", capb(0, 0), 8'hBC);
        chk("midrst_com_lane0_last", capb(0, 3), 8'hBC);
        nz = 0;
        for (int l = 0; l < LANES; l++)
            for (int i = 4; i < 10; i++) if (capb(l, i) != 8'h7C) nz++;
        chk("midrst_no_resend", nz, 0);

        // Randomised traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk_32f);
            valid_in = ($urandom % 2) == 1;
            data_in = $urandom;
            reset = ($urandom % 400) == 0;
        end
        @(negedge clk_32f); reset = 0; valid_in = 0;
        repeat (200) @(posedge clk_32f);

`ifdef PHY_TX_SKP_EN
        // SKP insertion during a continuous stream
        do_reset();
        repeat (40) @(posedge clk_32f);
        align();
        send_stream(20, 32'h40404040);
        repeat (100) @(posedge clk_32f); #1;
        s0 = find_byte(0, 8'h1C);
        chk("skp_found", s0 >= 0, 1);
        chk("skp_lane1_aligned", capb(1, s0), 8'h1C);
        chk("skp_next_interval", capb(0, s0 + 8), 8'h1C);
        nz = 0;
        for (int i = s0 + 1; i < s0 + 8; i++) if (capb(0, i) == 8'h1C) nz++;
        chk("skp_spacing", nz, 0);
        begin
            logic [7:0] flt[$];
            for (int i = 0; i < cap[0].size(); i++)
                if (cap[0][i] != 8'h1C && cap[0][i] != 8'h7C && cap[0][i] != 8'hBC) flt.push_back(cap[0][i]);
            mism = 0;
            for (int k = 0; k < 4; k++) begin
                w = 32'h40404040 + 32'(2 * k);
                for (int b = 0; b < 4; b++)
                    if (4 * k + b >= flt.size() || flt[4 * k + b] != w[31 - 8*b -: 8]) mism++;
            end
            chk("skp_words_intact", mism, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
